// File: rtl/pipe_fixed_point_accum.sv
// Streaming fixed-point frame accumulator: sums LEN valid samples in WII.WIF and
// emits one registered, rescaled WOI.WOF result per frame with overflow flags.
module pipe_fixed_point_accum #(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1,
    parameter int LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [WII+WIF-1:0]   in,
    output logic                 o_en,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);

    localparam int WAI   = WII + $clog2(LEN);
    localparam int WA    = WAI + WIF;
    localparam int WO    = WOI + WOF;
    localparam int CW    = (LEN > 1) ? $clog2(LEN) : 1;
    // Working width covers the widest integer and fraction parts plus a rounding carry.
    localparam int WX    = ((WAI > WOI) ? WAI : WOI) + ((WIF > WOF) ? WIF : WOF) + 2;
    localparam int SHL   = (WOF >= WIF) ? (WOF - WIF) : 0;
    localparam int SHR   = (WOF <  WIF) ? (WIF - WOF) : 0;
    localparam int SHRM1 = (SHR > 0) ? (SHR - 1) : 0;
    localparam bit RND_EN = (ROUND != 0) && (SHR > 0);

    localparam logic [CW-1:0]        LAST = CW'(LEN - 1);
    localparam logic signed [WX-1:0] RNDV = RND_EN ? (WX'(1) << SHRM1) : '0;
    localparam logic signed [WX-1:0] MAXV = {{(WX-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WX-1:0] MINV = {{(WX-WO+1){1'b1}}, {(WO-1){1'b0}}};

    logic signed [WA-1:0] acc;
    logic signed [WA-1:0] in_x;
    logic signed [WA-1:0] sum;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_eff;
    logic                 last;
    logic signed [WX-1:0] scaled;
    logic [WO-1:0]        res;
    logic                 res_up;
    logic                 res_dn;

    // A clear restarts the frame, so a sample arriving with it is treated as sample 0.
    always_comb begin
        cnt_eff = i_clr ? '0 : cnt;
        in_x    = WA'($signed(in));
        sum     = (cnt_eff == '0) ? in_x : (acc + in_x);
        last    = (cnt_eff == LAST);
    end

    // NOTE: every signal assigned in always_comb gets a value on all paths to avoid latches.
    always_comb begin
        scaled = ((WX'(sum) + RNDV) >>> SHR) <<< SHL;
        res_up = (scaled > MAXV);
        res_dn = (scaled < MINV);
        res    = scaled[WO-1:0];
        if (ROOF != 0) begin
            if (res_up)
                res = MAXV[WO-1:0];
            else if (res_dn)
                res = MINV[WO-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (i_en) begin
            acc <= sum;
            cnt <= last ? '0 : (cnt_eff + CW'(1));
        end else if (i_clr) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_en     <= 1'b0;
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else begin
            o_en <= i_en && last;
            if (i_en && last) begin
                out      <= res;
                upflow   <= res_up;
                downflow <= res_dn;
            end
        end
    end

endmodule

// File: tb/tb_pipe_fixed_point_accum.sv
// Self-checking bench: four parameter variants share one stimulus stream and are
// compared against a frame-level arithmetic reference model.
module tb_pipe_fixed_point_accum;

    localparam int LEN = 4;
    localparam int WIF = 8;
    localparam int WOI = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_clr;
    logic        i_en;
    logic [15:0] in;

    logic [3:0]  oe, up, dn;
    logic [15:0] o0, o1;
    logic [11:0] o2, o3;

    int n_checks = 0;
    int n_errors = 0;

    const int wofs [4] = '{8, 8, 4, 4};
    const int rnds [4] = '{1, 1, 1, 0};
    const int roofs[4] = '{1, 0, 1, 1};

    longint frame[$];
    longint last_out[4];
    bit     last_up[4];
    bit     last_dn[4];

    always #5 clk = ~clk;

    pipe_fixed_point_accum #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(1), .ROUND(1), .LEN(LEN)) u0 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_en(i_en), .in(in),
        .o_en(oe[0]), .out(o0), .upflow(up[0]), .downflow(dn[0]));
    pipe_fixed_point_accum #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(0), .ROUND(1), .LEN(LEN)) u1 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_en(i_en), .in(in),
        .o_en(oe[1]), .out(o1), .upflow(up[1]), .downflow(dn[1]));
    pipe_fixed_point_accum #(.WII(8), .WIF(8), .WOI(8), .WOF(4), .ROOF(1), .ROUND(1), .LEN(LEN)) u2 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_en(i_en), .in(in),
        .o_en(oe[2]), .out(o2), .upflow(up[2]), .downflow(dn[2]));
    pipe_fixed_point_accum #(.WII(8), .WIF(8), .WOI(8), .WOF(4), .ROOF(1), .ROUND(0), .LEN(LEN)) u3 (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_en(i_en), .in(in),
        .o_en(oe[3]), .out(o3), .upflow(up[3]), .downflow(dn[3]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact value of the frame sum in units of 2^-WIF, rescaled with plain integer math.
    function automatic void rescale(input longint sum, input int wof, input int rnd, input int roof,
                                    output longint o, output bit u, output bit d);
        longint s, m, x, mx, mn;
        if (wof >= WIF) begin
            s = sum * (longint'(1) << (wof - WIF));
        end else begin
            m = longint'(1) << (WIF - wof);
            x = sum + ((rnd != 0) ? m / 2 : 0);
            s = x / m;
            if ((x % m) != 0 && x < 0) s = s - 1;
        end
        mx = (longint'(1) << (WOI + wof - 1)) - 1;
        mn = -(longint'(1) << (WOI + wof - 1));
        u = (s > mx);
        d = (s < mn);
        if (roof != 0 && u) s = mx;
        if (roof != 0 && d) s = mn;
        o = s & ((longint'(1) << (WOI + wof)) - 1);
    endfunction

    function automatic longint get_out(input int k);
        case (k)
            0: return longint'(o0);
            1: return longint'(o1);
            2: return longint'(o2);
            default: return longint'(o3);
        endcase
    endfunction

    task automatic check_all(input bit pulse, input longint sum);
        longint o;
        bit u, d;
        for (int k = 0; k < 4; k++) begin
            if (pulse) begin
                rescale(sum, wofs[k], rnds[k], roofs[k], o, u, d);
                last_out[k] = o;
                last_up[k]  = u;
                last_dn[k]  = d;
            end
            check($sformatf("u%0d_o_en", k), longint'(oe[k]), longint'(pulse));
            check($sformatf("u%0d_out", k), get_out(k), last_out[k]);
            check($sformatf("u%0d_upflow", k), longint'(up[k]), longint'(last_up[k]));
            check($sformatf("u%0d_downflow", k), longint'(dn[k]), longint'(last_dn[k]));
        end
    endtask

    // Called at a falling edge: drive one cycle, predict, then check at the next falling edge.
    task automatic cycle(input logic en, input logic clr, input logic [15:0] d);
        bit     pulse = 1'b0;
        longint sum = 0;
        i_en  = en;
        i_clr = clr;
        in    = d;
        if (clr) frame.delete();
        if (en) begin
            frame.push_back(longint'($signed(d)));
            if (frame.size() == LEN) begin
                foreach (frame[j]) sum += frame[j];
                frame.delete();
                pulse = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all(pulse, sum);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_en  = 1'b0;
        i_clr = 1'b0;
        frame.delete();
        for (int k = 0; k < 4; k++) begin
            last_out[k] = 0;
            last_up[k]  = 1'b0;
            last_dn[k]  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(1'b0, 0);
        rst = 1'b0;
    endtask

    task automatic frame_of(input logic [15:0] d);
        for (int j = 0; j < LEN; j++) cycle(1'b1, 1'b0, d);
    endtask

    initial begin
        rst   = 1'b1;
        i_en  = 1'b0;
        i_clr = 1'b0;
        in    = '0;
        @(negedge clk);
        do_reset();

        frame_of(16'h0180);
        check("tp_1p5_out", longint'(o0), 64'h0600);
        cycle(1'b0, 1'b0, 16'h0000);

        frame_of(16'h6400);
        check("tp_sat_hi", longint'(o0), 64'h7FFF);
        check("tp_wrap_hi", longint'(o1), 64'h9000);
        frame_of(16'h9C00);
        check("tp_sat_lo", longint'(o0), 64'h8000);
        check("tp_wrap_lo", longint'(o1), 64'h7000);

        frame_of(16'h0002);
        check("tp_round_up", longint'(o2), 64'h001);
        check("tp_trunc", longint'(o3), 64'h000);
        frame_of(16'hFFFE);
        check("tp_round_neg", longint'(o2), 64'h000);

        for (int j = 0; j < 8; j++) cycle(1'b1, 1'b0, 16'h0100);
        check("tp_b2b_out", longint'(o0), 64'h0400);
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 16'($urandom));
            cycle(1'b1, 1'b0, 16'h0100);
        end
        check("tp_gaps_out", longint'(o0), 64'h0400);

        cycle(1'b1, 1'b0, 16'h0100);
        cycle(1'b1, 1'b0, 16'h0100);
        cycle(1'b1, 1'b1, 16'h0200);
        for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, 16'h0100);
        check("tp_clr_out", longint'(o0), 64'h0500);

        for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, 16'h0100);
        do_reset();
        frame_of(16'h0080);
        check("tp_rst_out", longint'(o0), 64'h0200);

        for (int j = 0; j < 600; j++) begin
            int r = $urandom_range(0, 99);
            logic [15:0] d;
            if ($urandom_range(0, 1) == 1)
                d = 16'($urandom);
            else
                d = 16'($urandom_range(0, 1023) - 512);
            if (r == 0)
                do_reset();
            else
                cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
